// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, multi-cycle
// results queue in a small FIFO and drain on idle port cycles.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     a_we,
  input  logic [4:0]               a_wa,
  input  logic [63:0]              a_wd,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_wa,
  input  logic [63:0]              b_wd,
  output logic                     rf_we,
  output logic [4:0]               rf_wa,
  output logic [63:0]              rf_wd,
  output logic                     pipe_stall,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]       wa_mem [DEPTH];
  logic [63:0]      wd_mem [DEPTH];
  logic [DEPTH-1:0] alive;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [7:0]       starve;
  logic             ready_en;

  logic a_req;
  logic empty;
  logic full;
  logic push;
  logic pop;

  assign a_req      = a_we && (a_wa != 5'd0);
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign b_ready    = ready_en && !full;
  assign push       = b_valid && b_ready;
  assign pop        = !a_req && !empty;
  assign pipe_stall = (starve >= 8'(STARVE_LIMIT));
  assign fifo_count = count;

  // Outputs are forced to zero while reset is held, even if a_we is driven.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = 5'd0;
    rf_wd = 64'd0;
    if (resetn) begin
      if (a_req) begin
        rf_we = 1'b1;
        rf_wa = a_wa;
        rf_wd = a_wd;
      end else if (!empty && alive[rd_ptr]) begin
        rf_we = 1'b1;
        rf_wa = wa_mem[rd_ptr];
        rf_wd = wd_mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem[wr_ptr] <= b_wa;
      wd_mem[wr_ptr] <= b_wd;
    end
  end

  // A pipeline write is younger than anything queued, so it kills matching entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alive <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (a_req && (wa_mem[i] == a_wa)) alive[i] <= 1'b0;
      end
      if (pop) alive[rd_ptr] <= 1'b0;
      if (push) alive[wr_ptr] <= (b_wa != 5'd0) && !(a_req && (b_wa == a_wa));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve <= 8'd0;
    end else if (empty || pop) begin
      starve <= 8'd0;
    end else if (starve != 8'hFF) begin
      starve <= starve + 8'd1;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written corner sequences
// and random traffic checked against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        clk;
  logic        resetn;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [63:0] a_wd;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_wa;
  logic [63:0] b_wd;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic        pipe_stall;
  logic [2:0]  fifo_count;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
    .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .pipe_stall(pipe_stall), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    logic [4:0]  wa;
    logic [63:0] wd;
    bit          alive;
  } ent_t;

  ent_t mq[$];
  int   m_deny;
  bit   m_en;

  logic        s_we;
  logic [4:0]  s_wa;
  logic [63:0] s_wd;
  logic        s_ready;
  logic        s_stall;
  logic [2:0]  s_cnt;
  int          wr_seen;

  typedef struct {
    logic        a_we;
    logic [4:0]  a_wa;
    logic [63:0] a_wd;
    logic        b_valid;
    logic [4:0]  b_wa;
    logic [63:0] b_wd;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_deny = 0;
    m_en   = 1'b0;
  endtask

  // One clock cycle: inputs are already driven; compare at negedge, advance model at the edge.
  task automatic cycle();
    bit          areq;
    bit          pop;
    bit          push;
    bit          was_empty;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    bit          e_ready;
    bit          e_stall;
    @(negedge clk);
    areq = a_we && (a_wa != 5'd0);
    e_we = 1'b0; e_wa = 5'd0; e_wd = 64'd0; pop = 1'b0;
    if (areq) begin
      e_we = 1'b1; e_wa = a_wa; e_wd = a_wd;
    end else if (mq.size() > 0) begin
      pop = 1'b1;
      if (mq[0].alive) begin
        e_we = 1'b1; e_wa = mq[0].wa; e_wd = mq[0].wd;
      end
    end
    e_ready = m_en && (mq.size() < DEPTH);
    e_stall = (m_deny >= STARVE_LIMIT);
    s_we = rf_we; s_wa = rf_wa; s_wd = rf_wd;
    s_ready = b_ready; s_stall = pipe_stall; s_cnt = fifo_count;
    if (rf_we) wr_seen++;
    check("rf_we", 64'(s_we), 64'(e_we));
    check("rf_wa", 64'(s_wa), 64'(e_wa));
    check("rf_wd", s_wd, e_wd);
    check("b_ready", 64'(s_ready), 64'(e_ready));
    check("pipe_stall", 64'(s_stall), 64'(e_stall));
    check("fifo_count", 64'(s_cnt), 64'(mq.size()));
    push      = b_valid && e_ready;
    was_empty = (mq.size() == 0);
    if (areq) begin
      foreach (mq[i]) if (mq[i].wa == a_wa) mq[i].alive = 1'b0;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{b_wa, b_wd, (b_wa != 5'd0) && !(areq && (b_wa == a_wa))});
    if (was_empty || pop) m_deny = 0;
    else if (m_deny < 255) m_deny++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_we = 1'b0; a_wa = 5'd0; a_wd = 64'd0;
    b_valid = 1'b0; b_wa = 5'd0; b_wd = 64'd0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    m_en = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; wr_seen = 0;
    idle_inputs();
    model_reset();
    resetn = 1'b0;

    //               a_we  a_wa   a_wd     bv    b_wa   b_wd     e_we  e_wa   e_wd     cnt
    tbl[0]  = '{1'b0, 5'd0, 64'h00, 1'b1, 5'd5, 64'hAA, 1'b0, 5'd0, 64'h00, 3'd0};
    tbl[1]  = '{1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 1'b1, 5'd5, 64'hAA, 3'd1};
    tbl[2]  = '{1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 3'd0};
    tbl[3]  = '{1'b0, 5'd0, 64'h00, 1'b1, 5'd7, 64'h11, 1'b0, 5'd0, 64'h00, 3'd0};
    tbl[4]  = '{1'b1, 5'd7, 64'h22, 1'b0, 5'd0, 64'h00, 1'b1, 5'd7, 64'h22, 3'd1};
    tbl[5]  = '{1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 3'd1};
    tbl[6]  = '{1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 3'd0};
    tbl[7]  = '{1'b0, 5'd0, 64'h00, 1'b1, 5'd9, 64'h33, 1'b0, 5'd0, 64'h00, 3'd0};
    tbl[8]  = '{1'b1, 5'd0, 64'h44, 1'b0, 5'd0, 64'h00, 1'b1, 5'd9, 64'h33, 3'd1};
    tbl[9]  = '{1'b0, 5'd0, 64'h00, 1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'h00, 3'd0};
    tbl[10] = '{1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 3'd1};
    tbl[11] = '{1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 3'd0};
    tbl[12] = '{1'b1, 5'd6, 64'h66, 1'b1, 5'd6, 64'h77, 1'b1, 5'd6, 64'h66, 3'd0};
    tbl[13] = '{1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 3'd1};
    tbl[14] = '{1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 1'b0, 5'd0, 64'h00, 3'd0};

    // Reset state, with a pipeline write attempted while reset is held.
    a_we = 1'b1; a_wa = 5'd9; a_wd = 64'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rf_we", 64'(rf_we), 64'd0);
    check("rst_rf_wa", 64'(rf_wa), 64'd0);
    check("rst_rf_wd", rf_wd, 64'd0);
    check("rst_b_ready", 64'(b_ready), 64'd0);
    check("rst_pipe_stall", 64'(pipe_stall), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    idle_inputs();
    release_reset();
    check("post_rst_b_ready", 64'(b_ready), 64'd1);

    for (int i = 0; i < 15; i++) begin
      a_we = tbl[i].a_we; a_wa = tbl[i].a_wa; a_wd = tbl[i].a_wd;
      b_valid = tbl[i].b_valid; b_wa = tbl[i].b_wa; b_wd = tbl[i].b_wd;
      cycle();
      check($sformatf("tbl%0d_we", i), 64'(s_we), 64'(tbl[i].e_we));
      check($sformatf("tbl%0d_wa", i), 64'(s_wa), 64'(tbl[i].e_wa));
      check($sformatf("tbl%0d_wd", i), s_wd, tbl[i].e_wd);
      check($sformatf("tbl%0d_cnt", i), 64'(s_cnt), 64'(tbl[i].e_cnt));
    end
    idle_inputs();

    // Fill under continuous pipeline writes, starve, then drain in push order.
    a_we = 1'b1; a_wa = 5'd3; a_wd = 64'hA3;
    for (int k = 0; k < 4; k++) begin
      b_valid = 1'b1; b_wa = 5'(10 + k); b_wd = 64'(100 + k);
      cycle();
    end
    b_valid = 1'b0;
    for (int c = 4; c < 12; c++) begin
      cycle();
      if (c == 4) begin
        check("full_cnt", 64'(s_cnt), 64'd4);
        check("full_b_ready", 64'(s_ready), 64'd0);
      end
      if (c == 8) check("stall_before_limit", 64'(s_stall), 64'd0);
      if (c == 9) check("stall_at_limit", 64'(s_stall), 64'd1);
    end
    a_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("drain_we", 64'(s_we), 64'd1);
      check("drain_wa", 64'(s_wa), 64'(10 + k));
      check("drain_wd", s_wd, 64'(100 + k));
      if (k == 0) check("stall_held_until_pop", 64'(s_stall), 64'd1);
      if (k == 1) check("stall_cleared_by_pop", 64'(s_stall), 64'd0);
    end
    cycle();
    check("drain_empty_cnt", 64'(s_cnt), 64'd0);

    // Three buffered, then simultaneous push and pop keeps the count.
    a_we = 1'b1; a_wa = 5'd1; a_wd = 64'h1;
    for (int k = 0; k < 3; k++) begin
      b_valid = 1'b1; b_wa = 5'(20 + k); b_wd = 64'(200 + k);
      cycle();
    end
    a_we = 1'b0; b_valid = 1'b1; b_wa = 5'd23; b_wd = 64'd203;
    cycle();
    check("pushpop_cnt_before", 64'(s_cnt), 64'd3);
    check("pushpop_wa", 64'(s_wa), 64'd20);
    b_valid = 1'b0;
    cycle();
    check("pushpop_cnt_after", 64'(s_cnt), 64'd3);
    for (int c = 0; c < 20; c++) begin
      a_we = ($urandom_range(0, 1) == 1);
      a_wa = 5'($urandom_range(24, 31)); a_wd = {$urandom, $urandom};
      if (!(b_valid && !s_ready)) begin
        b_valid = ($urandom_range(0, 1) == 1);
        b_wa = 5'($urandom_range(16, 23)); b_wd = {$urandom, $urandom};
      end
      cycle();
    end
    idle_inputs();
    repeat (6) cycle();

    // Asynchronous reset mid-drain discards buffered entries.
    a_we = 1'b1; a_wa = 5'd2; a_wd = 64'h2;
    for (int k = 0; k < 3; k++) begin
      b_valid = 1'b1; b_wa = 5'(24 + k); b_wd = 64'(240 + k);
      cycle();
    end
    b_valid = 1'b0; a_we = 1'b0;
    cycle();
    check("middrain_cnt", 64'(s_cnt), 64'd3);
    a_we = 1'b1; a_wa = 5'd4; a_wd = 64'h4;
    #2;
    resetn = 1'b0;
    #1;
    check("async_rf_we", 64'(rf_we), 64'd0);
    check("async_rf_wa", 64'(rf_wa), 64'd0);
    check("async_rf_wd", rf_wd, 64'd0);
    check("async_b_ready", 64'(b_ready), 64'd0);
    check("async_pipe_stall", 64'(pipe_stall), 64'd0);
    check("async_fifo_count", 64'(fifo_count), 64'd0);
    model_reset();
    idle_inputs();
    @(posedge clk);
    release_reset();
    wr_seen = 0;
    repeat (6) cycle();
    check("no_write_after_reset", 64'(wr_seen), 64'd0);

    // Random traffic with narrow address ranges to provoke kills and x0 cases.
    for (int c = 0; c < 400; c++) begin
      a_we = ($urandom_range(0, 9) < 6);
      a_wa = 5'($urandom_range(0, 7)); a_wd = {$urandom, $urandom};
      if (!(b_valid && !s_ready)) begin
        b_valid = ($urandom_range(0, 9) < 5);
        b_wa = 5'($urandom_range(0, 7)); b_wd = {$urandom, $urandom};
      end
      cycle();
    end
    idle_inputs();
    repeat (8) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
